// File: rtl/serial_io_pkg.sv
// Shared types and constants for the serial I/O controller.
//   DATA_W/FRAME_W/TMO_W : payload, receiver frame and timeout counter widths
//   TAG_DATA/TAG_EOF     : receiver frame tags in rx_data[9:8]
//   state_e              : controller FSM state encoding
package serial_io_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned TMO_W   = 16;

    localparam logic [TMO_W-1:0] TIMEOUT_CYCLES_DEF = 16'd50000;

    localparam logic [1:0] TAG_DATA = 2'b10;
    localparam logic [1:0] TAG_EOF  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RX_WAIT,
        RX_FLUSH,
        TX_START,
        TX_WAIT,
        ACK
    } state_e;

endpackage

// File: rtl/io_timeout.sv
// Down-counting watchdog for the serial wait states.
//   clk, rst  : clock, synchronous active-high reset
//   load      : reload the counter with load_val (wins over enable)
//   enable    : decrement by one per cycle, saturating at zero
//   load_val  : reload value
//   expired   : registered flag, high while the counter holds zero
module io_timeout
    import serial_io_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [TMO_W-1:0] load_val,
    output logic             expired
);

    logic [TMO_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // Next count; expired is derived from the next value so it lines up with count_q
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - TMO_W'(1);
        end
        expired_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/serial_io_ctrl.sv
// CPU-side controller bridging single-byte read/write requests onto a
// serial receiver and transmitter, with a per-transfer timeout.
//   in_req/out_req/out_data : CPU requests (levels held until ack)
//   ack/in_data/in_eof/err  : completion pulse, received payload, EOF, sticky timeout
//   busy                    : controller not idle
//   rx_enable/rx_done/rx_data          : receiver handshake and 10-bit tagged frame
//   tx_start/tx_data/tx_busy/tx_done   : transmitter handshake
module serial_io_ctrl
    import serial_io_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_req,
    input  logic               out_req,
    input  logic [DATA_W-1:0]  out_data,
    output logic               ack,
    output logic [DATA_W-1:0]  in_data,
    output logic               in_eof,
    output logic               err,
    output logic               busy,
    output logic               rx_enable,
    input  logic               rx_done,
    input  logic [FRAME_W-1:0] rx_data,
    output logic               tx_start,
    output logic [DATA_W-1:0]  tx_data,
    input  logic               tx_busy,
    input  logic               tx_done
);

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] in_data_q, in_data_d;
    logic              in_eof_q, in_eof_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rx_enable_q, rx_enable_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic              tmo_load_c;
    logic              tmo_enable_c;
    logic              tmo_expired;

    io_timeout u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (tmo_load_c),
        .enable   (tmo_enable_c),
        .load_val (TMO_W'(TIMEOUT_CYCLES - TMO_W'(1))),
        .expired  (tmo_expired)
    );

    // Next state and next registered outputs
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        in_data_d = '0;
        in_eof_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending write blocks reads even while the transmitter is busy
                if (out_req) begin
                    if (!tx_busy) begin
                        state_d   = TX_START;
                        tx_data_d = out_data;
                        err_d     = 1'b0;
                    end
                end else if (in_req) begin
                    state_d = RX_WAIT;
                    err_d   = 1'b0;
                end
            end
            RX_WAIT: begin
                // A frame arriving on the last counter cycle still completes normally
                if (rx_done) begin
                    if (rx_data[9:8] == TAG_DATA) begin
                        state_d   = ACK;
                        in_data_d = rx_data[DATA_W-1:0];
                    end else if (rx_data[9:8] == TAG_EOF) begin
                        state_d  = ACK;
                        in_eof_d = 1'b1;
                    end else begin
                        state_d = RX_FLUSH;
                    end
                end else if (tmo_expired) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                end
            end
            RX_FLUSH: state_d = RX_WAIT;
            TX_START: state_d = TX_WAIT;
            TX_WAIT: begin
                if (tx_done) begin
                    state_d = ACK;
                end else if (tmo_expired) begin
                    state_d = ACK;
                    err_d   = 1'b1;
                end
            end
            ACK:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        ack_d       = (state_d == ACK);
        busy_d      = (state_d != IDLE);
        rx_enable_d = (state_d == RX_WAIT);
        tx_start_d  = (state_d == TX_START);

        // Reload on every entry into a wait state, including RX_FLUSH -> RX_WAIT
        tmo_load_c   = ((state_d == RX_WAIT) || (state_d == TX_WAIT)) && (state_d != state_q);
        tmo_enable_c = (state_q == RX_WAIT) || (state_q == TX_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            in_data_q   <= '0;
            in_eof_q    <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            rx_enable_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            in_data_q   <= in_data_d;
            in_eof_q    <= in_eof_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            rx_enable_q <= rx_enable_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign ack       = ack_q;
    assign in_data   = in_data_q;
    assign in_eof    = in_eof_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign rx_enable = rx_enable_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;

endmodule

// File: doc/serial_io_ctrl.md
SERIAL_IO_CTRL -- requirements
Module: serial_io_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, meaning max clk cycles spent waiting on the serial rx/tx before abort.
REQ-002 SHALL have clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have in_req  input  1  CPU requests one input byte (level, held until ack).
REQ-005 SHALL have out_req  input  1  CPU requests one output byte (level, held until ack).
REQ-006 SHALL have out_data  input  8  byte to transmit, sampled when out_req is accepted.
REQ-007 SHALL have ack  output  1  one-cycle completion pulse for the accepted request.
REQ-008 SHALL have in_data  output  8  received payload, valid while ack=1 and in_eof=0, else 0.
REQ-009 SHALL have in_eof  output  1  received frame was end-of-input, valid with ack.
REQ-010 SHALL have err  output  1  sticky timeout flag.
REQ-011 SHALL have busy  output  1  high in every state except IDLE.
REQ-012 SHALL have rx_enable  output  1  enable to the serial receiver.
REQ-013 SHALL have rx_done, rx_data  input  1, 10  receiver frame-complete flag and 10-bit frame.
REQ-014 SHALL have tx_start  output  1, tx_data  output  8, tx_busy  input  1, tx_done  input  1  transmitter handshake.

Function
REQ-015 SHALL implement FSM states IDLE, RX_WAIT, RX_FLUSH, TX_START, TX_WAIT, ACK; all outputs registered.
REQ-016 IDLE: out_req=1 and tx_busy=0 -> TX_START, latch out_data into tx_data; else in_req=1 -> RX_WAIT; out_req wins when both requests are high in the same cycle.
REQ-017 IDLE with out_req=1 and tx_busy=1 SHALL not accept either request and SHALL stay in IDLE.
REQ-018 rx_enable SHALL be 1 exactly while in RX_WAIT (asserted the cycle after acceptance).
REQ-019 RX_WAIT with rx_done=1: frame tag rx_data[9:8]=2'b10 -> in_data=rx_data[7:0], in_eof=0, go ACK; tag 2'b11 -> in_data=0, in_eof=1, go ACK.
REQ-020 RX_WAIT with rx_done=1 and tag 2'b00/2'b01 SHALL discard the frame and go RX_FLUSH.
REQ-021 RX_FLUSH SHALL last one cycle with rx_enable=0 to clear the receiver, then return to RX_WAIT with the timeout counter reloaded.
REQ-022 TX_START SHALL pulse tx_start=1 for exactly one cycle, then go TX_WAIT; TX_WAIT with tx_done=1 -> ACK.
REQ-023 ACK SHALL drive ack=1 for one cycle, then go IDLE; the requester drops its req upon seeing ack.
REQ-024 Latency: input request accepted at cycle N gives rx_enable=1 at N+1; rx_done at cycle M gives ack at M+1. Output request accepted at N gives tx_start at N+1; tx_done at cycle M gives ack at M+1.
REQ-025 Timeout counter SHALL load TIMEOUT_CYCLES-1 on entry to RX_WAIT/TX_WAIT and decrement each cycle in those states; at 0 without done -> ACK with err=1, in_data=0, in_eof=0.
REQ-026 rx_done/tx_done coinciding with counter=0 SHALL complete normally (done wins; err unchanged).
REQ-027 err SHALL clear when the next request is accepted in IDLE.
REQ-028 in_data/in_eof SHALL return to 0 the cycle after ack.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and ack=0, in_data=0, in_eof=0, err=0, busy=0, rx_enable=0, tx_start=0, tx_data=0, timeout counter=0, including mid-transfer.
REQ-030 The first request SHALL be accepted no earlier than the first edge with rst=0.

Structure
REQ-031 Package serial_io_pkg SHALL hold the state encoding, frame tag constants (TAG_DATA=2'b10, TAG_EOF=2'b11) and the TIMEOUT_CYCLES default.
REQ-032 The timeout counter SHALL be sub-module io_timeout (load, enable, expired outputs); the FSM and datapath live in serial_io_ctrl.

Verification
REQ-033 in_req, rx_done with rx_data=10'h2A5 three cycles later -> single ack pulse, in_data=8'hA5, in_eof=0, rx_enable low after ack.
REQ-034 in_req and out_req rise together with out_data=8'h3C -> tx_start with tx_data=8'h3C first; after ack and out_req drop, input serviced.
REQ-035 in_req, rx_data=10'h07F (bad tag) then 10'h300 -> one rx_enable=0 cycle, then ack with in_eof=1, in_data=0.
REQ-036 TIMEOUT_CYCLES=8, out_req, tx_done never -> ack exactly 8 cycles after TX_WAIT entry, err=1, sticky until next acceptance.
REQ-037 rst=1 during RX_WAIT -> next edge rx_enable=0, busy=0, state IDLE; a late rx_done produces no ack.
REQ-038 out_req with tx_busy=1 for 5 cycles -> no tx_start until tx_busy=0, then tx_start one cycle later.
